// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array tile sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // Weight load: N rows are read, and the last column needs time to settle.
  function automatic int unsigned load_len(input int unsigned n);
    return 3 * n - 2;
  endfunction

  // Drain: the last vector's partial sums must fall out of the array.
  function automatic int unsigned drain_len(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_window.sv
// Skewed window decode: flag i is high while base+i <= cnt < base+i+len.
// Ports: en gates all flags; cnt/base/len are CNT_W wide; win_c is N flags.
module skew_window #(
  parameter int unsigned N     = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] base,
  input  logic [CNT_W-1:0] len,
  output logic [N-1:0]     win_c
);

  localparam int unsigned AW = CNT_W + 2;

  // Two extra bits so base+i+len never wraps.
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      win_c[i] = en
        && ({2'b00, cnt} >= ({2'b00, base} + AW'(i)))
        && ({2'b00, cnt} <  ({2'b00, base} + AW'(i) + {2'b00, len}));
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for an N x N systolic PE array: weight load with column
// skew, row-skewed switch wave, row-skewed input streaming, then drain.
// Ports: clk/rst (async, active-high); start/num_vec/abort control;
// w_rd_en/w_row_idx to the weight buffer; col_accept_w, row_switch,
// row_valid to the array edges; in_rd_en to the input buffer; busy, done.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             abort,
  output logic             w_rd_en,
  output logic [IDX_W-1:0] w_row_idx,
  output logic [N-1:0]     col_accept_w,
  output logic [N-1:0]     row_switch,
  output logic [N-1:0]     row_valid,
  output logic [N-1:0]     in_rd_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LOAD_LEN  = load_len(N);
  localparam int unsigned DRAIN_LEN = drain_len(N);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   nv_q, nv_d;
  logic               done_q, done_d;

  logic               w_rd_en_q, w_rd_en_d;
  logic [IDX_W-1:0]   w_row_idx_q, w_row_idx_d;
  logic [N-1:0]       col_accept_w_q, col_accept_w_d;
  logic [N-1:0]       row_switch_q, row_switch_d;
  logic [N-1:0]       row_valid_q, row_valid_d;
  logic               busy_q, busy_d;

  // Next state and counter; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    nv_d    = nv_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          if (num_vec != '0) begin
            nv_d    = num_vec;
            state_d = LOAD_W;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (cnt_q == CNT_W'(LOAD_LEN - 1)) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (cnt_q == nv_q + CNT_W'(N - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Outputs are decoded from the next state so the flops present the value
  // belonging to the cycle that state occupies.
  logic [N-1:0] acc_win_c, valid_win_c;

  skew_window #(.N(N), .CNT_W(CNT_W)) u_acc_win (
    .en    (state_d == LOAD_W),
    .cnt   (cnt_d),
    .base  ('0),
    .len   (CNT_W'(N)),
    .win_c (acc_win_c)
  );

  skew_window #(.N(N), .CNT_W(CNT_W)) u_valid_win (
    .en    (state_d == STREAM),
    .cnt   (cnt_d),
    .base  (CNT_W'(1)),
    .len   (nv_d),
    .win_c (valid_win_c)
  );

  always_comb begin
    w_rd_en_d      = (state_d == LOAD_W) && (cnt_d < CNT_W'(N));
    w_row_idx_d    = '0;
    col_accept_w_d = acc_win_c;
    row_valid_d    = valid_win_c;
    row_switch_d   = '0;
    busy_d         = (state_d != IDLE);
    // Bottom row is read first so it ends up deepest in the column.
    if (w_rd_en_d) begin
      w_row_idx_d = IDX_W'(CNT_W'(N - 1) - cnt_d);
    end
    for (int unsigned r = 0; r < N; r++) begin
      row_switch_d[r] = (state_d == STREAM) && (cnt_d == CNT_W'(r));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      nv_q           <= '0;
      done_q         <= 1'b0;
      w_rd_en_q      <= 1'b0;
      w_row_idx_q    <= '0;
      col_accept_w_q <= '0;
      row_switch_q   <= '0;
      row_valid_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      nv_q           <= nv_d;
      done_q         <= done_d;
      w_rd_en_q      <= w_rd_en_d;
      w_row_idx_q    <= w_row_idx_d;
      col_accept_w_q <= col_accept_w_d;
      row_switch_q   <= row_switch_d;
      row_valid_q    <= row_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign w_rd_en      = w_rd_en_q;
  assign w_row_idx    = w_row_idx_q;
  assign col_accept_w = col_accept_w_q;
  assign row_switch   = row_switch_q;
  assign row_valid    = row_valid_q;
  assign in_rd_en     = row_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifndef SYNTHESIS
  // The stream counter has no wrap handling, so num_vec+N must fit.
  a_num_vec_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE && start && !abort) |->
      (({1'b0, num_vec} + (CNT_W+1)'(N)) <= (CNT_W+1)'((2 ** CNT_W) - 1)));
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: an N=2 and an N=4 instance share stimulus and are
// checked every cycle against a timeline model of the tile operation.
module tb_systolic_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;

  always #5 clk = ~clk;

  logic       w_rd_en0, busy0, done0;
  logic [0:0] idx0;
  logic [1:0] acc0, sw0, val0, inrd0;
  logic       w_rd_en1, busy1, done1;
  logic [1:0] idx1;
  logic [3:0] acc1, sw1, val1, inrd1;

  systolic_ctrl #(.N(2), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .abort(abort),
    .w_rd_en(w_rd_en0), .w_row_idx(idx0), .col_accept_w(acc0),
    .row_switch(sw0), .row_valid(val0), .in_rd_en(inrd0),
    .busy(busy0), .done(done0)
  );

  systolic_ctrl #(.N(4), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .abort(abort),
    .w_rd_en(w_rd_en1), .w_row_idx(idx1), .col_accept_w(acc1),
    .row_switch(sw1), .row_valid(val1), .in_rd_en(inrd1),
    .busy(busy1), .done(done1)
  );

  // Timeline model: an operation is (start cycle t0, vector count); every
  // output is a closed-form function of the offset k from t0.
  int nn [2] = '{2, 4};
  bit act [2];
  bit done_exp [2];
  int t0 [2];
  int nvm [2];
  int cyc = 0;
  int kp, tot;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0;
        done_exp[i] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        done_exp[i] = 1'b0;
        if (act[i]) begin
          kp  = cyc - 1 - t0[i];
          tot = (3 * nn[i] - 2) + (nvm[i] + nn[i]) + 2 * nn[i];
          if (abort) act[i] = 1'b0;
          else if (kp == tot - 1) begin
            act[i] = 1'b0;
            done_exp[i] = 1'b1;
          end
        end else if (start && !abort) begin
          if (num_vec != '0) begin
            act[i] = 1'b1;
            t0[i]  = cyc;
            nvm[i] = int'(num_vec);
          end else begin
            done_exp[i] = 1'b1;
          end
        end
      end
    end
  end

  // Hand-derived completion offsets for the directed scenarios (-1: none).
  int lit_done [2] = '{-1, -1};
  int lit_v3 = -1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input int i, input int a, input int e);
    vectors = vectors + 1;
    if (a != e) begin
      miscompares = miscompares + 1;
      $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", nm, i, cyc, a, e);
    end
  endtask

  int k, n, lw, e_idx;
  logic [3:0] e_acc, e_sw, e_val, d_acc, d_sw, d_val, d_inrd;
  logic e_rd, d_rd, d_busy, d_done;
  int d_idx;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      n  = nn[i];
      k  = cyc - t0[i];
      lw = 3 * n - 2;
      e_rd  = act[i] && (k < n);
      e_idx = e_rd ? (n - 1 - k) : 0;
      e_acc = '0; e_sw = '0; e_val = '0;
      for (int c = 0; c < n; c++) begin
        e_acc[c] = act[i] && (k >= c) && (k < c + n);
        e_sw[c]  = act[i] && (k == lw + c);
        e_val[c] = act[i] && (k >= lw + c + 1) && (k <= lw + c + nvm[i]);
      end
      if (i == 0) begin
        d_rd = w_rd_en0; d_idx = int'(idx0); d_acc = {2'b00, acc0};
        d_sw = {2'b00, sw0}; d_val = {2'b00, val0}; d_inrd = {2'b00, inrd0};
        d_busy = busy0; d_done = done0;
      end else begin
        d_rd = w_rd_en1; d_idx = int'(idx1); d_acc = acc1;
        d_sw = sw1; d_val = val1; d_inrd = inrd1;
        d_busy = busy1; d_done = done1;
      end
      check("busy", i, int'(d_busy), int'(act[i]));
      check("done", i, int'(d_done), int'(done_exp[i]));
      check("w_rd_en", i, int'(d_rd), int'(e_rd));
      check("w_row_idx", i, d_idx, e_idx);
      check("col_accept_w", i, int'(d_acc), int'(e_acc));
      check("row_switch", i, int'(d_sw), int'(e_sw));
      check("row_valid", i, int'(d_val), int'(e_val));
      check("in_rd_en", i, int'(d_inrd), int'(e_val));
      // Literal anchors independent of the timeline formulas.
      if (d_done && lit_done[i] >= 0) check("lit_done_cycle", i, k, lit_done[i]);
      if (i == 0 && d_sw[0]) check("lit_sw0_cycle", i, k, 4);
      if (i == 0 && d_sw[1]) check("lit_sw1_cycle", i, k, 5);
      if (i == 0 && d_rd) check("lit_row_idx", i, d_idx, (k == 0) ? 1 : 0);
      if (i == 1 && d_acc[3]) check("lit_acc3_window", i, int'(k >= 3 && k <= 6), 1);
      if (i == 1 && d_val[3] && lit_v3 >= 0) check("lit_valid3_cycle", i, k, lit_v3);
    end
  end

  // Drive start for one cycle; returns at the negedge of cycle 0.
  task automatic go(input int nv);
    start = 1'b1;
    num_vec = CNT_W'(nv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic N=2/N=4 run with a stray start at cycle 3.
    lit_done[0] = 13; lit_done[1] = 25;
    go(3);
    idle(3);
    start = 1'b1; num_vec = CNT_W'(2);
    @(negedge clk);
    start = 1'b0;
    idle(30);

    // Zero-length request completes at once without going busy.
    lit_done[0] = -1; lit_done[1] = -1;
    go(0);
    idle(3);

    // Abort at cycle 6, restart at cycle 8.
    lit_done[0] = 13; lit_done[1] = 25;
    go(3);
    idle(6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    go(3);
    idle(30);

    // N=4 single vector.
    lit_done[0] = 11; lit_done[1] = 23; lit_v3 = 14;
    go(1);
    idle(30);
    lit_v3 = -1;

    // Abort together with start in IDLE blocks the start.
    lit_done[0] = -1; lit_done[1] = -1;
    start = 1'b1; abort = 1'b1; num_vec = CNT_W'(2);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    idle(3);

    // Asynchronous reset in the middle of cycle 5.
    go(3);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);

    // Randomised traffic.
    for (int j = 0; j < 400; j++) begin
      start   = ($urandom % 4) == 0;
      num_vec = CNT_W'($urandom_range(0, 5));
      abort   = ($urandom % 25) == 0;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
